// File: rtl/strike_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : strike_control_pkg
// Description : Shared ISA opcode constants and FSM state encodings for the
//               strike controller. The testbench imports this package to
//               decode the debug state port.
// Revision    : 1.0 - initial release
// ============================================================================
package strike_control_pkg;

    // Opcode field IR[7:6]
    localparam logic [1:0] c_op_halt  = 2'b00;
    localparam logic [1:0] c_op_wleds = 2'b01;
    localparam logic [1:0] c_op_jp    = 2'b10;
    localparam logic [1:0] c_op_nop   = 2'b11;

    // Controller state encoding, exposed on the state port
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Preset for the down-counting fetch wait timer (counts FETCH_WAIT cycles)
    function automatic logic [1:0] wait_preset(input int fetch_wait);
        return 2'(fetch_wait - 1);
    endfunction

endpackage : strike_control_pkg
`default_nettype wire

// File: rtl/strike_control_if.sv
`default_nettype none
// ============================================================================
// Module      : strike_control_if
// Description : Control/status bundle between the strike controller and its
//               datapath. Optional macro STRIKE_STEP_EN adds the step input.
//               master = controller side, slave = datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface strike_control_if;
    logic [1:0] co;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       leds_load;
    logic       halt;
    logic [2:0] state;
    logic [7:0] instr_count;
`ifdef STRIKE_STEP_EN
    logic       step;

    modport master (
        input  co, step,
        output ir_load, pc_inc, pc_load, leds_load, halt, state, instr_count
    );
    modport slave (
        output co, step,
        input  ir_load, pc_inc, pc_load, leds_load, halt, state, instr_count
    );
`else
    modport master (
        input  co,
        output ir_load, pc_inc, pc_load, leds_load, halt, state, instr_count
    );
    modport slave (
        output co,
        input  ir_load, pc_inc, pc_load, leds_load, halt, state, instr_count
    );
`endif
endinterface : strike_control_if
`default_nettype wire

// File: rtl/strike_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : strike_wait_timer
// Description : 2-bit down counter that times the ROM read latency. Loaded
//               with FETCH_WAIT-1 on entry to FETCH; done_o flags the last
//               wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module strike_wait_timer
    import strike_control_pkg::*;
#(
    parameter int FETCH_WAIT = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load_i,
    input  wire logic en_i,
    output logic      done_o
);

    localparam logic [1:0] c_preset = wait_preset(FETCH_WAIT);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: reload on FETCH entry, otherwise count down to zero and hold
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = c_preset;
        end else if (en_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 2'd0);

endmodule : strike_wait_timer
`default_nettype wire

// File: rtl/strike_control.sv
`default_nettype none
// ============================================================================
// Module      : strike_control
// Description : Fetch/load/execute control FSM for the strike processor.
//               Moore outputs decoded from the state register (plus co in
//               EXEC), 8-bit wrapping executed-instruction counter.
//               Optional macro STRIKE_STEP_EN: single-step gating in FETCH.
// Revision    : 1.0 - initial release
// ============================================================================
module strike_control
    import strike_control_pkg::*;
#(
    parameter int FETCH_WAIT = 1
) (
    input  wire logic        clock,
    input  wire logic        reset_ini,
    strike_control_if.master bus
);

    state_t     state_q;
    logic [7:0] count_q;

    logic w_timer_load;
    logic w_timer_en;
    logic w_timer_done;
    logic w_fetch_done;

`ifdef STRIKE_STEP_EN
    // Set on leaving EXEC; the FETCH wait only starts once step is seen
    logic step_wait_q;

    assign w_timer_load = (state_q == ST_INIT) || (state_q == ST_EXEC) ||
                          ((state_q == ST_FETCH) && step_wait_q && bus.step);
    assign w_timer_en   = (state_q == ST_FETCH) && !step_wait_q;
    assign w_fetch_done = (state_q == ST_FETCH) && !step_wait_q && w_timer_done;

    // Step gate: armed after every instruction, released by a sampled step
    always_ff @(posedge clock) begin
        if (reset_ini) begin
            step_wait_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            step_wait_q <= 1'b1;
        end else if ((state_q == ST_FETCH) && bus.step) begin
            step_wait_q <= 1'b0;
        end
    end
`else
    assign w_timer_load = (state_q == ST_INIT) || (state_q == ST_EXEC);
    assign w_timer_en   = (state_q == ST_FETCH);
    assign w_fetch_done = (state_q == ST_FETCH) && w_timer_done;
`endif

    strike_wait_timer #(
        .FETCH_WAIT (FETCH_WAIT)
    ) u_wait_timer (
        .clk    (clock),
        .rst    (reset_ini),
        .load_i (w_timer_load),
        .en_i   (w_timer_en),
        .done_o (w_timer_done)
    );

    // Main FSM and executed-instruction counter; reset overrides every arc
    always_ff @(posedge clock) begin
        if (reset_ini) begin
            state_q <= ST_INIT;
            count_q <= 8'd0;
        end else begin
            case (state_q)
                ST_INIT:   state_q <= ST_FETCH;
                ST_FETCH:  if (w_fetch_done) state_q <= ST_LOAD;
                ST_LOAD:   state_q <= ST_EXEC;
                ST_EXEC: begin
                    count_q <= count_q + 8'd1;
                    state_q <= (bus.co == c_op_halt) ? ST_HALTED : ST_FETCH;
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_INIT;
            endcase
        end
    end

    // Strobe decode: only LOAD and EXEC drive strobes, co matters only in EXEC
    always_comb begin
        bus.ir_load   = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_load   = 1'b0;
        bus.leds_load = 1'b0;
        bus.halt      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                bus.ir_load = 1'b1;
                bus.pc_inc  = 1'b1;
            end
            ST_EXEC: begin
                case (bus.co)
                    c_op_halt:  bus.halt      = 1'b1;
                    c_op_wleds: bus.leds_load = 1'b1;
                    c_op_jp:    bus.pc_load   = 1'b1;
                    default:    ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule : strike_control
`default_nettype wire

// File: tb/tb_strike_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_strike_control
// Description : Self-checking bench for strike_control. Instance A
//               (FETCH_WAIT=1) runs directed programs against a cycle
//               scoreboard; instance B (FETCH_WAIT=3) runs a NOP loop for
//               period and counter-wrap checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strike_control;
    import strike_control_pkg::*;

    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    strike_control_if ifa ();
    strike_control_if ifb ();

    strike_control #(.FETCH_WAIT(1)) dut_a (
        .clock     (clock),
        .reset_ini (rst_a),
        .bus       (ifa.master)
    );

    strike_control #(.FETCH_WAIT(3)) dut_b (
        .clock     (clock),
        .reset_ini (rst_b),
        .bus       (ifb.master)
    );

    // strb = {ir_load, pc_inc, pc_load, leds_load, halt}
    typedef struct packed {
        logic [2:0] st;
        logic [4:0] strb;
        logic [7:0] cnt;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       g_last;
    logic [2:0] m_st;
    logic [7:0] m_cnt;
    logic [1:0] prog[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_strobes(input logic [2:0] st, input logic [1:0] c);
        logic [4:0] s;
        s = 5'b00000;
        if (st == ST_LOAD) begin
            s = 5'b11000;
        end else if (st == ST_EXEC) begin
            case (c)
                2'b00:   s = 5'b00001;
                2'b01:   s = 5'b00010;
                2'b10:   s = 5'b00100;
                default: s = 5'b00000;
            endcase
        end
        return s;
    endfunction

    // One cycle of instance A: drive at negedge, score at +1, advance model
    task automatic tick_a(input logic [1:0] c, input logic r);
        obs_t e;
        obs_t g;
        rst_a  = r;
        ifa.co = c;
        e.st   = m_st;
        e.strb = model_strobes(m_st, c);
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        #1;
        g = {ifa.state, ifa.ir_load, ifa.pc_inc, ifa.pc_load,
             ifa.leds_load, ifa.halt, ifa.instr_count};
        g_last = g;
        e = exp_q.pop_front();
        check("a_state",   32'(g.st),   32'(e.st));
        check("a_strobes", 32'(g.strb), 32'(e.strb));
        check("a_count",   32'(g.cnt),  32'(e.cnt));
        check("a_onehot",  32'($countones({g.strb[4], g.strb[2:0]}) <= 1), 32'd1);
        check("a_inc_wo_ir", 32'(g.strb[3] & ~g.strb[4]), 32'd0);
        @(posedge clock);
        if (r) begin
            m_st  = ST_INIT;
            m_cnt = 8'd0;
        end else begin
            case (m_st)
                ST_INIT:  m_st = ST_FETCH;
                ST_FETCH: m_st = ST_LOAD;
                ST_LOAD:  m_st = ST_EXEC;
                ST_EXEC: begin
                    m_cnt = m_cnt + 8'd1;
                    m_st  = (c == 2'b00) ? ST_HALTED : ST_FETCH;
                end
                default: ;
            endcase
        end
        @(negedge clock);
    endtask

    // Opcode for the next cycle: program entry in EXEC, random noise elsewhere
    function automatic logic [1:0] pick_co();
        if ((m_st == ST_EXEC) && (prog.size() > 0)) return prog.pop_front();
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        int last_ir;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        ifa.co = 2'b11;
        ifb.co = 2'b11;
`ifdef STRIKE_STEP_EN
        ifa.step = 1'b1;
        ifb.step = 1'b1;
`endif
        repeat (3) @(posedge clock);
        @(negedge clock);
        m_st  = ST_INIT;
        m_cnt = 8'd0;

        // Program 0:WLEDS 5, 1:JP 3, 3:HALT with co noise outside EXEC
        prog = '{2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 30; i++) begin
            tick_a(pick_co(), 1'b0);
            if (i == 0)  check("p_init",      32'(g_last.st), 32'(ST_INIT));
            if (i == 1)  check("p_fetch1",    32'(g_last.st), 32'(ST_FETCH));
            if (i == 2)  check("p_ir_load",   32'(g_last.strb), 32'b11000);
            if (i == 3)  check("p_leds_load", 32'(g_last.strb), 32'b00010);
            if (i == 4)  check("p_fetch2",    32'(g_last.st), 32'(ST_FETCH));
            if (i == 4)  check("p_count1",    32'(g_last.cnt), 32'd1);
            if (i == 6)  check("p_pc_load",   32'(g_last.strb), 32'b00100);
            if (i == 9)  check("p_halt",      32'(g_last.strb), 32'b00001);
            if (i >= 10) check("p_halted",    32'(g_last.st), 32'(ST_HALTED));
            if (i == 29) check("p_count3",    32'(g_last.cnt), 32'd3);
        end

        // Reset pulse while HALTED
        tick_a(2'($urandom_range(0, 3)), 1'b1);
        tick_a(2'b00, 1'b0);
        check("rh_init",  32'(g_last.st), 32'(ST_INIT));
        check("rh_count", 32'(g_last.cnt), 32'd0);
        check("rh_strb",  32'(g_last.strb), 32'd0);

        // Reset pulse in the second FETCH cycle, then keep running
        prog = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
        for (int i = 1; i < 20; i++) begin
            tick_a(pick_co(), (i == 4));
            if (i == 4) check("rf_fetch", 32'(g_last.st), 32'(ST_FETCH));
            if (i == 5) check("rf_init",  32'(g_last.st), 32'(ST_INIT));
            if (i == 5) check("rf_count", 32'(g_last.cnt), 32'd0);
            if (i == 5) check("rf_strb",  32'(g_last.strb), 32'd0);
            if (i == 6) check("rf_fetch2", 32'(g_last.st), 32'(ST_FETCH));
        end
        rst_a = 1'b1;

        // Instance B: FETCH_WAIT=3 NOP loop, 5-cycle period and count wrap
        ifb.co  = 2'b11;
        rst_b   = 1'b0;
        last_ir = -1;
        for (int k = 0; k < 1290; k++) begin
            #1;
            if (k == 0) check("b_init",  32'(ifb.state), 32'(ST_INIT));
            if (k == 1) check("b_fetch", 32'(ifb.state), 32'(ST_FETCH));
            if (k == 3) check("b_fetch3", 32'(ifb.state), 32'(ST_FETCH));
            if (k == 4) check("b_load",  32'(ifb.state), 32'(ST_LOAD));
            if (k == 6) check("b_count1", 32'(ifb.instr_count), 32'd1);
            if (k == 1280) check("b_count255", 32'(ifb.instr_count), 32'd255);
            if (k == 1281) check("b_wrap",     32'(ifb.instr_count), 32'd0);
            check("b_strobes", 32'({ifb.pc_load, ifb.leds_load, ifb.halt}), 32'd0);
            check("b_inc_ir",  32'(ifb.pc_inc), 32'(ifb.ir_load));
            if (ifb.ir_load) begin
                if (last_ir >= 0) check("b_period", 32'(k - last_ir), 32'd5);
                last_ir = k;
            end
            @(negedge clock);
        end
        check("b_seen_loads", 32'(last_ir > 1200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_strike_control
`default_nettype wire
